// File: rtl/log_sched_pkg.sv
// Shared types and defaults for the river-log lane scheduler.
package log_sched_pkg;
    localparam int NUM_LANES = 6;
    localparam int DIV_W     = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSED = 2'd3
    } state_e;

    localparam logic [DIV_W-1:0] DEF_DIV0 = 24'd200000;
    localparam logic [DIV_W-1:0] DEF_DIV1 = 24'd100000;
    localparam logic [DIV_W-1:0] DEF_DIV2 = 24'd275000;
    localparam logic [DIV_W-1:0] DEF_DIV3 = 24'd190000;
    localparam logic [DIV_W-1:0] DEF_DIV4 = 24'd350000;
    localparam logic [DIV_W-1:0] DEF_DIV5 = 24'd150000;
    localparam logic [NUM_LANES-1:0] DEF_DIR_MASK = 6'b101010;
    localparam logic [DIV_W-1:0] DEF_MIN_DIV = 24'd1000;

    // Faster levels halve the period per step, but never below the floor.
    function automatic logic [DIV_W-1:0] scaled_div(input logic [DIV_W-1:0] base,
                                                    input logic [1:0] lvl,
                                                    input logic [DIV_W-1:0] floor_div);
        logic [DIV_W-1:0] shifted;
        shifted = base >> lvl;
        return (shifted < floor_div) ? floor_div : shifted;
    endfunction
endpackage

// File: rtl/log_sched_if.sv
// Control/status bundle between the game logic and the log scheduler.
interface log_sched_if;
    logic                                 start;
    logic                                 pause;
    logic [1:0]                           level;
    logic                                 level_load;
    logic [2:0]                           frog_lane;
    logic                                 frog_on_log;
    logic [log_sched_pkg::NUM_LANES-1:0]  lane_step;
    logic [log_sched_pkg::NUM_LANES-1:0]  lane_dir;
    logic                                 carry_step;
    logic                                 carry_dir;
    logic                                 busy;
    logic [1:0]                           state;

    modport master (
        output start, pause, level, level_load, frog_lane, frog_on_log,
        input  lane_step, lane_dir, carry_step, carry_dir, busy, state
    );
    modport slave (
        input  start, pause, level, level_load, frog_lane, frog_on_log,
        output lane_step, lane_dir, carry_step, carry_dir, busy, state
    );
endinterface

// File: rtl/lane_tick_gen.sv
// One lane's step timer: counts enabled cycles, strobes one cycle after reaching div.
module lane_tick_gen import log_sched_pkg::*; (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             step
);
    logic [DIV_W-1:0] cnt;
    logic             hit;

    // >= so a divider lowered below the running count fires immediately.
    assign hit = en && (cnt >= div);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            step <= hit;
            if (clr || hit)
                cnt <= '0;
            else if (en)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/log_scheduler.sv
// Loads per-lane step dividers for the selected speed level, then paces the six log lanes.
module log_scheduler import log_sched_pkg::*; #(
    parameter logic [DIV_W-1:0]     LANE_DIV0 = DEF_DIV0,
    parameter logic [DIV_W-1:0]     LANE_DIV1 = DEF_DIV1,
    parameter logic [DIV_W-1:0]     LANE_DIV2 = DEF_DIV2,
    parameter logic [DIV_W-1:0]     LANE_DIV3 = DEF_DIV3,
    parameter logic [DIV_W-1:0]     LANE_DIV4 = DEF_DIV4,
    parameter logic [DIV_W-1:0]     LANE_DIV5 = DEF_DIV5,
    parameter logic [NUM_LANES-1:0] DIR_MASK  = DEF_DIR_MASK,
    parameter logic [DIV_W-1:0]     MIN_DIV   = DEF_MIN_DIV
) (
    input  logic      clk,
    input  logic      reset,
    log_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_LOAD   = ST_LOAD;
    localparam logic [1:0] S_RUN    = ST_RUN;
    localparam logic [1:0] S_PAUSED = ST_PAUSED;

    localparam logic [NUM_LANES-1:0][DIV_W-1:0] LANE_BASE =
        {LANE_DIV5, LANE_DIV4, LANE_DIV3, LANE_DIV2, LANE_DIV1, LANE_DIV0};

    logic [1:0]                        state_q, state_n;
    logic [1:0]                        level_q;
    logic [2:0]                        load_idx;
    logic [NUM_LANES-1:0][DIV_W-1:0]   div_q;
    logic [NUM_LANES-1:0]              step;
    logic                              go_load;
    logic                              run_en;

    always_comb begin
        state_n = state_q;
        go_load = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_n = S_LOAD;
                go_load = 1'b1;
            end
            S_LOAD: if (load_idx == 3'd5)
                state_n = bus.pause ? S_PAUSED : S_RUN;
            S_RUN, S_PAUSED: begin
                if (bus.level_load) begin
                    state_n = S_LOAD;
                    go_load = 1'b1;
                end else begin
                    state_n = bus.pause ? S_PAUSED : S_RUN;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Counting only while staying in RUN keeps every registered step inside RUN.
    assign run_en = (state_q == S_RUN) && (state_n == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            level_q  <= 2'd0;
            load_idx <= 3'd0;
            div_q    <= '0;
        end else begin
            state_q <= state_n;
            if (go_load) begin
                level_q  <= bus.level;
                load_idx <= 3'd0;
            end else if (state_q == S_LOAD) begin
                div_q[load_idx] <= scaled_div(LANE_BASE[load_idx], level_q, MIN_DIV);
                load_idx        <= (load_idx == 3'd5) ? 3'd0 : load_idx + 3'd1;
            end
        end
    end

    lane_tick_gen u_lane [NUM_LANES-1:0] (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .clr   (go_load),
        .div   (div_q),
        .step  (step)
    );

    always_comb begin
        bus.carry_step = 1'b0;
        bus.carry_dir  = 1'b0;
        if (bus.frog_lane < 3'd6) begin
            bus.carry_step = step[bus.frog_lane] & bus.frog_on_log;
            bus.carry_dir  = DIR_MASK[bus.frog_lane];
        end
    end

    assign bus.lane_step = step;
    assign bus.lane_dir  = DIR_MASK;
    assign bus.busy      = (state_q == S_LOAD);
    assign bus.state     = state_q;
endmodule

// File: tb/tb_log_scheduler.sv
// Randomized and directed stimulus against a cycle-level reference model, checked by a scoreboard.
module tb_log_scheduler;
    localparam int IDLE = 0, LOAD = 1, RUN = 2, PAUSED = 3;
    localparam logic [5:0] DIRM = 6'b101010;
    localparam int MINDIV = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    log_sched_if bus();

    log_scheduler #(
        .LANE_DIV0(24'd4), .LANE_DIV1(24'd5), .LANE_DIV2(24'd6),
        .LANE_DIV3(24'd7), .LANE_DIV4(24'd8), .LANE_DIV5(24'd9),
        .DIR_MASK(6'b101010), .MIN_DIV(24'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        logic [5:0] step;
    } exp_t;
    exp_t q[$];

    int base [6] = '{4, 5, 6, 7, 8, 9};
    int m_st = IDLE;
    int m_lvl = 0;
    int m_ld = 0;
    int m_div [6];
    int m_el [6];

    task automatic model_enter_load();
        m_lvl = int'(bus.level);
        m_ld  = 0;
        m_st  = LOAD;
        for (int k = 0; k < 6; k++) m_el[k] = 0;
    endtask

    // Reference: each lane steps on every (div+1)-th cycle spent running.
    always @(posedge clk) begin
        logic [5:0] nstep;
        exp_t e;
        nstep = '0;
        if (reset) begin
            m_st = IDLE; m_lvl = 0; m_ld = 0;
            for (int k = 0; k < 6; k++) begin m_el[k] = 0; m_div[k] = 0; end
        end else begin
            case (m_st)
                IDLE: if (bus.start) model_enter_load();
                LOAD: begin
                    m_ld++;
                    if (m_ld == 6) begin
                        for (int k = 0; k < 6; k++) begin
                            m_div[k] = base[k] / (1 << m_lvl);
                            if (m_div[k] < MINDIV) m_div[k] = MINDIV;
                        end
                        m_st = bus.pause ? PAUSED : RUN;
                    end
                end
                RUN: begin
                    if (bus.level_load) model_enter_load();
                    else if (bus.pause) m_st = PAUSED;
                    else begin
                        for (int k = 0; k < 6; k++) begin
                            m_el[k]++;
                            if (m_el[k] == m_div[k] + 1) begin
                                nstep[k] = 1'b1;
                                m_el[k]  = 0;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.level_load) model_enter_load();
                    else if (!bus.pause) m_st = RUN;
                end
            endcase
        end
        e.st = m_st;
        e.step = nstep;
        q.push_back(e);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ec, ed;
        if (q.size() > 0) begin
            e = q.pop_front();
            ec = 1'b0;
            ed = 1'b0;
            if (bus.frog_lane < 3'd6) begin
                ec = e.step[bus.frog_lane] & bus.frog_on_log;
                ed = DIRM[bus.frog_lane];
            end
            chk("state",      32'(bus.state),      32'(e.st));
            chk("busy",       32'(bus.busy),       32'(e.st == LOAD));
            chk("lane_step",  32'(bus.lane_step),  32'(e.step));
            chk("carry_step", 32'(bus.carry_step), 32'(ec));
            chk("carry_dir",  32'(bus.carry_dir),  32'(ed));
            chk("lane_dir",   32'(bus.lane_dir),   32'(DIRM));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] lvl);
        bus.level = lvl; bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_load(input logic [1:0] lvl);
        bus.level = lvl; bus.level_load = 1'b1;
        cyc(1);
        bus.level_load = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.pause = 0; bus.level = 0; bus.level_load = 0;
        bus.frog_lane = 3'd3; bus.frog_on_log = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Level 0: lane 0 period 5, lane 5 period 10; frog riding lane 3.
        pulse_start(2'd0);
        cyc(45);
        // Freeze mid-phase, then resume.
        bus.pause = 1'b1; cyc(20);
        bus.pause = 1'b0; cyc(30);
        // Level 2 reload, frog off the river.
        bus.frog_lane = 3'd7;
        pulse_load(2'd2);
        cyc(30);
        // Reload and pause in the same cycle: LOAD first, then PAUSED.
        bus.frog_lane = 3'd4; bus.frog_on_log = 1'b1;
        bus.pause = 1'b1;
        pulse_load(2'd1);
        cyc(12);
        bus.pause = 1'b0; cyc(25);
        // Level 3 drives lane 0 to the divider floor; stray strobes during LOAD.
        bus.frog_lane = 3'd0;
        pulse_load(2'd3);
        bus.start = 1'b1; bus.level_load = 1'b1; bus.level = 2'd0;
        cyc(2);
        bus.start = 1'b0; bus.level_load = 1'b0;
        cyc(20);
        // Start pressed while paused in IDLE.
        reset = 1'b1; cyc(1); reset = 1'b0;
        bus.pause = 1'b1;
        pulse_start(2'd1);
        cyc(10);
        bus.pause = 1'b0; cyc(15);
        // Reset lands on the third LOAD cycle.
        reset = 1'b1; cyc(1); reset = 1'b0;
        pulse_start(2'd0);
        cyc(2);
        reset = 1'b1; cyc(1); reset = 1'b0;
        cyc(3);

        for (int i = 0; i < 600; i++) begin
            bus.start       = ($urandom_range(0, 19) == 0);
            bus.level_load  = ($urandom_range(0, 29) == 0);
            bus.level       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.pause = ~bus.pause;
            bus.frog_lane   = 3'($urandom_range(0, 7));
            bus.frog_on_log = 1'($urandom_range(0, 1));
            reset           = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        reset = 1'b0; bus.start = 0; bus.level_load = 0;
        cyc(2);

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/log_scheduler.md
LOG_SCHEDULER -- requirements
Module: log_scheduler

Interface
REQ-001 Parameter LANE_DIV0..LANE_DIV5, defaults 200000/100000/275000/190000/350000/150000, base per-lane step period minus one, in clk cycles.
REQ-002 Parameter DIR_MASK, default 6'b101010, per-lane direction, bit=1 moves right (+x), bit=0 moves left (-x).
REQ-003 Parameter MIN_DIV, default 24'd1000, floor on any scaled divider.
REQ-004 clk  input  1  system clock; single clock domain, all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle strobe; begins configuration then motion.
REQ-007 pause  input  1  level input; high freezes all lane counters.
REQ-008 level  input  2  speed level 0..3, sampled only on start or level_load.
REQ-009 level_load  input  1  one-cycle strobe; reloads dividers at new level while running.
REQ-010 frog_lane  input  3  river lane occupied by frog, 0..5; values 6..7 mean none.
REQ-011 frog_on_log  input  1  frog overlaps a log in frog_lane.
REQ-012 lane_step  output  6  one-cycle step strobe per lane.
REQ-013 lane_dir  output  6  equals DIR_MASK, constant.
REQ-014 carry_step  output  1  one-cycle strobe: frog must move one pixel with its log.
REQ-015 carry_dir  output  1  direction for carry_step, DIR_MASK bit of frog_lane.
REQ-016 busy  output  1  high in LOAD state.
REQ-017 state  output  2  current FSM state encoding.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, PAUSED.
REQ-019 IDLE->LOAD on start; level latched into level_q same cycle.
REQ-020 LOAD SHALL write one lane divider per cycle, lanes 0..5 in order, exactly 6 cycles, then enter RUN.
REQ-021 Loaded divider SHALL be max(LANE_DIVk >> level_q, MIN_DIV), 24-bit unsigned.
REQ-022 Entering LOAD SHALL clear all six lane counters to 0.
REQ-023 In RUN, each lane counter SHALL increment by 1 per cycle; when counter >= divider, lane_step[k] asserts for that cycle and counter returns to 0, giving period divider+1.
REQ-024 lane_step SHALL be registered: asserted the cycle after the counter compare is true, zero in all states except RUN.
REQ-025 RUN->PAUSED when pause=1; PAUSED->RUN when pause=0; counters hold value in PAUSED.
REQ-026 RUN or PAUSED ->LOAD on level_load; level latched; level_load SHALL take priority over pause.
REQ-027 start, level_load SHALL be ignored while in LOAD; start ignored outside IDLE.
REQ-028 start with pause=1 in IDLE SHALL still enter LOAD; after LOAD, go to PAUSED if pause=1.
REQ-029 carry_step SHALL equal lane_step[frog_lane] & frog_on_log, same cycle as lane_step, forced 0 when frog_lane>5.
REQ-030 carry_dir SHALL equal DIR_MASK[frog_lane], 0 when frog_lane>5.
REQ-031 Counters SHALL never wrap; compare uses >=, so a divider reduced mid-count steps next cycle.

Reset
REQ-032 On reset: state=IDLE, all counters 0, all dividers 0, level_q 0, lane_step 0, carry_step 0, busy 0; load index 0.
REQ-033 Reset SHALL override every other input in the same cycle, including during LOAD.

Structure
REQ-034 Package log_sched_pkg SHALL hold the state enum, NUM_LANES=6, default dividers, DIR_MASK default, MIN_DIV.
REQ-035 Sub-module lane_tick_gen SHALL implement one lane counter (en, clr, div in; step out), instantiated six times.

Verification
REQ-036 Dividers overridden to 4,5,6,7,8,9, MIN_DIV=1, level 0, start -> busy high 6 cycles, then lane_step[0] every 5 cycles, lane_step[5] every 10.
REQ-037 Same config, level=2 on start -> lane 4 divider 2 (period 3), lane 0 divider 1 (MIN_DIV floor, period 2).
REQ-038 pause high 20 cycles during RUN -> no lane_step during pause, phase resumes exactly where it stopped.
REQ-039 frog_lane=3, frog_on_log=1 -> carry_step coincident with each lane_step[3], carry_dir=1; frog_lane=7 -> carry_step never asserts.
REQ-040 level_load together with pause in RUN -> LOAD entered, counters 0, then PAUSED.
REQ-041 reset asserted on 3rd LOAD cycle -> next cycle state=IDLE, busy=0, all outputs 0.
